is_uart_rx: RTL and testbench

UART receive deserialiser. It sits directly downstream of the RX pad (uart_data_rx_i) and the baud-rate enable generator is_uart_ce inside is_uart_top, and feeds received bytes to the controller logic. It oversamples the asynchronous RX line on a tick enable, validates start/stop (and optional parity), and emits one-cycle strobes per byte or error.

---
 rtl/is_pkg_uart_controller.sv | 25 ++
 rtl/is_sync_2ff.sv | 27 ++
 rtl/is_uart_rx.sv | 150 +++++++++++++++
 tb/tb_is_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/is_pkg_uart_controller.sv
// Shared types, defaults and helpers for the UART controller blocks.
//   uart_rx_state_t : receive FSM state encoding
//   UART_OVERSAMPLE : default oversample ticks per bit
//   UART_DATA_BITS  : default payload width
//   uart_parity()   : expected parity bit for a payload (zero-extended to 8 bits)
package is_pkg_uart_controller;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/is_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs.
//   i_clk  : destination clock
//   i_rstn : asynchronous reset, active low
//   i_d    : asynchronous input
//   o_q    : synchronised output (RESET_VAL while in reset)
module is_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= {2{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/is_uart_rx.sv
// UART receive deserialiser. Oversamples the RX line on uart_ce_i ticks, samples each bit
// at mid-bit, checks start/stop and optional parity, and emits one-cycle result strobes.
//   clk_i          : system clock
//   rstn_i         : asynchronous reset, active low
//   uart_ce_i      : oversample tick, OVERSAMPLE per bit
//   uart_data_rx_i : asynchronous serial line, idle high
//   data_o         : last good byte, LSB first received
//   data_valid_o   : strobe, data_o updated
//   frame_err_o    : strobe, stop bit sampled low
//   parity_err_o   : strobe, parity mismatch
//   busy_o         : receiver not idle
module is_uart_rx
  import is_pkg_uart_controller::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 uart_ce_i,
  input  logic                 uart_data_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 busy_o
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_mid;
  logic                 w_end;
  logic [7:0]           w_par_data;
  logic                 w_par_exp;
  uart_rx_state_t       w_state_d;

  uart_rx_state_t       r_state;
  logic [TICK_W-1:0]    r_tick;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_busy;

  is_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk  (clk_i),
    .i_rstn (rstn_i),
    .i_d    (uart_data_rx_i),
    .o_q    (w_rx_s)
  );

  assign w_mid = uart_ce_i && (r_tick == TICK_MID);
  assign w_end = uart_ce_i && (r_tick == TICK_LAST);

  always_comb begin
    w_par_data                  = '0;
    w_par_data[DATA_BITS-1:0]   = r_shift;
    w_par_exp                   = uart_parity(w_par_data, PARITY_ODD != 0);
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:      if (uart_ce_i && !w_rx_s) w_state_d = START;
      START: begin
        if (w_mid && w_rx_s) w_state_d = IDLE;  // false start
        else if (w_end)      w_state_d = DATA;
      end
      DATA:      if (w_end && (r_bit == BIT_LAST)) w_state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (w_end) w_state_d = STOP;
      // Leave at mid-stop so a back-to-back start edge is not missed.
      STOP:      if (w_mid) w_state_d = w_rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (uart_ce_i && w_rx_s) w_state_d = IDLE;
      default:   w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d != IDLE);
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;

      if (w_state_d != r_state) begin
        r_tick <= '0;
      end else if (uart_ce_i) begin
        r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
      end

      case (r_state)
        START: begin
          r_bit     <= '0;
          r_par_err <= 1'b0;
        end
        DATA: begin
          if (w_mid) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (w_end) r_bit <= (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
        end
        PARITY: begin
          if (w_mid) r_par_err <= (w_rx_s != w_par_exp);
        end
        STOP: begin
          if (w_mid) begin
            if (!w_rx_s) begin
              r_ferr <= 1'b1;
            end else if (r_par_err) begin
              r_perr <= 1'b1;
            end else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign frame_err_o  = r_ferr;
  assign parity_err_o = r_perr;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_is_uart_rx.sv
// Directed bench for is_uart_rx: one instance without parity, one with even parity.
module tb_is_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       rstn;
  logic       ce;
  logic       rx0;
  logic       rx1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       valid0, ferr0, perr0, busy0;
  logic       valid1, ferr1, perr1, busy1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cnt_v0 = 0, cnt_f0 = 0, cnt_p0 = 0;
  int cnt_v1 = 0, cnt_f1 = 0, cnt_p1 = 0;
  int last_v0_cyc = 0;
  logic [7:0] q0[$];

  is_uart_rx #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .PARITY_EN  (0),
    .PARITY_ODD (0)
  ) u_dut0 (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .uart_ce_i      (ce),
    .uart_data_rx_i (rx0),
    .data_o         (data0),
    .data_valid_o   (valid0),
    .frame_err_o    (ferr0),
    .parity_err_o   (perr0),
    .busy_o         (busy0)
  );

  is_uart_rx #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) u_dut1 (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .uart_ce_i      (ce),
    .uart_data_rx_i (rx1),
    .data_o         (data1),
    .data_valid_o   (valid1),
    .frame_err_o    (ferr1),
    .parity_err_o   (perr1),
    .busy_o         (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Tick every 4 clocks, so one bit is 64 clocks.
  initial begin
    ce = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (valid0) begin
      cnt_v0++;
      last_v0_cyc = cyc;
      q0.push_back(data0);
    end
    if (ferr0) cnt_f0++;
    if (perr0) cnt_p0++;
    if (valid1) cnt_v1++;
    if (ferr1) cnt_f1++;
    if (perr1) cnt_p1++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (par_en) drive_bit(which, par_bit);
    drive_bit(which, stop_bit);
  endtask

  int base_v;
  int start_cyc;
  int lat;

  initial begin
    rstn = 1'b0;
    rx0  = 1'b1;
    rx1  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data0", 32'(data0), 32'h0);
    check_eq("rst_valid0", 32'(valid0), 32'h0);
    check_eq("rst_ferr0", 32'(ferr0), 32'h0);
    check_eq("rst_perr0", 32'(perr0), 32'h0);
    check_eq("rst_busy0", 32'(busy0), 32'h0);
    check_eq("rst_busy1", 32'(busy1), 32'h0);
    rstn = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // 1: plain frame, latency ~9.5 bits after the start edge
    base_v    = cnt_v0;
    start_cyc = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    lat = last_v0_cyc - start_cyc;
    check_eq("t1_valid_cnt", 32'(cnt_v0 - base_v), 32'd1);
    check_eq("t1_data", 32'(data0), 32'hA5);
    check_eq("t1_busy", 32'(busy0), 32'h0);
    check_eq("t1_latency_ok", 32'(lat >= 600 && lat <= 620), 32'd1);
    check_eq("t1_no_err", 32'(cnt_f0 + cnt_p0), 32'd0);

    // 2: short glitch is a false start
    rx0 = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("t2_busy_start", 32'(busy0), 32'h1);
    rx0 = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check_eq("t2_busy_after", 32'(busy0), 32'h0);
    check_eq("t2_no_strobe", 32'(cnt_v0 - base_v + cnt_f0 + cnt_p0), 32'd1);
    check_eq("t2_data_kept", 32'(data0), 32'hA5);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check_eq("t2_data", 32'(data0), 32'h3C);
    check_eq("t2_valid_cnt", 32'(cnt_v0 - base_v), 32'd2);

    // 3: stop bit low followed by a break
    base_v = cnt_v0;
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (3 * BIT_CLK) @(negedge clk);
    check_eq("t3_busy_break", 32'(busy0), 32'h1);
    check_eq("t3_ferr_cnt", 32'(cnt_f0), 32'd1);
    check_eq("t3_no_valid", 32'(cnt_v0 - base_v), 32'd0);
    check_eq("t3_no_perr", 32'(cnt_p0), 32'd0);
    check_eq("t3_data_kept", 32'(data0), 32'h3C);
    rx0 = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check_eq("t3_busy_idle", 32'(busy0), 32'h0);
    check_eq("t3_ferr_once", 32'(cnt_f0), 32'd1);

    // 4: even parity, 0x07 needs parity bit 1
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    check_eq("t4_perr_cnt", 32'(cnt_p1), 32'd1);
    check_eq("t4_no_valid", 32'(cnt_v1), 32'd0);
    check_eq("t4_no_ferr", 32'(cnt_f1), 32'd0);
    check_eq("t4_data_kept", 32'(data1), 32'h0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    check_eq("t4_valid_cnt", 32'(cnt_v1), 32'd1);
    check_eq("t4_data", 32'(data1), 32'h07);
    check_eq("t4_perr_once", 32'(cnt_p1), 32'd1);

    // 5: back-to-back frames
    base_v = cnt_v0;
    q0.delete();
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    check_eq("t5_valid_cnt", 32'(cnt_v0 - base_v), 32'd2);
    check_eq("t5_first", (q0.size() >= 1) ? 32'(q0[0]) : 32'hDEAD, 32'h00);
    check_eq("t5_second", (q0.size() >= 2) ? 32'(q0[1]) : 32'hDEAD, 32'hFF);
    check_eq("t5_data", 32'(data0), 32'hFF);

    // 6: reset during data bit 4 of 0x81; the sender abandons that frame
    base_v = cnt_v0;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, (i == 0) ? 1'b1 : 1'b0);
    rx0 = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    rstn = 1'b0;
    rx0  = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t6_rst_data", 32'(data0), 32'h0);
    check_eq("t6_rst_busy", 32'(busy0), 32'h0);
    check_eq("t6_rst_strobes", 32'({valid0, ferr0, perr0}), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check_eq("t6_no_valid", 32'(cnt_v0 - base_v), 32'd0);
    check_eq("t6_busy_idle", 32'(busy0), 32'h0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check_eq("t6_valid_cnt", 32'(cnt_v0 - base_v), 32'd1);
    check_eq("t6_data", 32'(data0), 32'h5A);
    check_eq("t6_errs", 32'(cnt_f0 + cnt_p0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
